// File: rtl/alu_pkg.sv
// Shared types for the ALU command issuer: command/response records,
// opcode encodings and the issuer FSM state.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } alu_cmd_t;

    typedef struct packed {
        logic [7:0] y;
        logic       co;
    } alu_rsp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } issuer_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands; guarded push/pop, no read bypass.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  alu_cmd_t                 push_data,
    input  logic                     pop,
    output alu_cmd_t                 pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t       mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Extra pointer bit distinguishes full from empty when addresses match.
    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == (AW + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Feeds queued commands to the ALU one at a time and returns each result
// on a valid/ready response port.
//   state  | meaning
//   S_IDLE | no op in flight; pop as soon as the FIFO holds a command
//   S_WAIT | operands on the ALU; latency down-counter running
//   S_RESP | result captured and offered; held until consumer accepts
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic [3:0]               cmd_op,
    output logic [7:0]               alu_a_in,
    output logic [7:0]               alu_b_in,
    output logic [3:0]               alu_opcode_in,
    input  logic [7:0]               alu_y_out,
    input  logic                     alu_co_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_y,
    output logic                     rsp_co,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              op_count
);

    localparam int CW = $clog2(ALU_LATENCY + 1);

    issuer_state_t  state;
    logic [CW-1:0]  lat_cnt;
    alu_rsp_t       rsp_q;
    alu_cmd_t       head_cmd;
    alu_cmd_t       new_cmd;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;

    assign new_cmd   = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !fifo_full;
    assign rsp_y     = rsp_q.y;
    assign rsp_co    = rsp_q.co;
    // A pop happens exactly when the FSM is free to start the next operation.
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (cmd_valid),
        .push_data (new_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            lat_cnt       <= '0;
            alu_a_in      <= '0;
            alu_b_in      <= '0;
            alu_opcode_in <= '0;
            rsp_valid     <= 1'b0;
            rsp_q         <= '0;
            op_count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        alu_a_in      <= head_cmd.a;
                        alu_b_in      <= head_cmd.b;
                        alu_opcode_in <= head_cmd.op;
                        lat_cnt       <= CW'(ALU_LATENCY);
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == CW'(1)) begin
                        rsp_q     <= '{y: alu_y_out, co: alu_co_out};
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        if (pop) begin
                            alu_a_in      <= head_cmd.a;
                            alu_b_in      <= head_cmd.b;
                            alu_opcode_in <= head_cmd.op;
                            lat_cnt       <= CW'(ALU_LATENCY);
                            state         <= S_WAIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Randomized and directed bench for alu_op_issuer with a behavioural ALU
// and a queue-based scoreboard checked by an independent monitor.
module tb_alu_op_issuer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [7:0]             cmd_a = '0;
    logic [7:0]             cmd_b = '0;
    logic [3:0]             cmd_op = '0;
    logic [7:0]             alu_a_in;
    logic [7:0]             alu_b_in;
    logic [3:0]             alu_opcode_in;
    logic [7:0]             alu_y_out;
    logic                   alu_co_out;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [7:0]             rsp_y;
    logic                   rsp_co;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0]            op_count;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [8:0]  exp_q[$];
    int          hs_cyc[$];
    logic [15:0] exp_cnt = '0;
    logic        hold_chk = 1'b0;
    logic [8:0]  held = '0;

    alu_op_issuer #(.DEPTH(DEPTH), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .alu_opcode_in(alu_opcode_in),
        .alu_y_out(alu_y_out), .alu_co_out(alu_co_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_co(rsp_co),
        .fifo_level(fifo_level), .op_count(op_count)
    );

    // Result {carry, y} of an 8-bit ALU operation.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        case (op)
            ALU_ADD: return {1'b0, a} + {1'b0, b};
            ALU_SUB: return {1'b0, a} - {1'b0, b};
            ALU_AND: return {1'b0, a & b};
            ALU_OR:  return {1'b0, a | b};
            ALU_XOR: return {1'b0, a ^ b};
            default: return 9'h000;
        endcase
    endfunction

    assign {alu_co_out, alu_y_out} = alu_ref(alu_a_in, alu_b_in, alu_opcode_in);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: records accepted commands and checks every response handshake.
    always @(negedge clk) begin
        if (reset) begin
            n_cmp++;
            if (op_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL op_count: got %h want %h", op_count, exp_cnt);
            end
            if (hold_chk) begin
                n_cmp++;
                if (!rsp_valid || {rsp_co, rsp_y} !== held) begin
                    n_fail++;
                    $display("FAIL rsp_hold: got v=%b %h want v=1 %h", rsp_valid, {rsp_co, rsp_y}, held);
                end
            end
            if (cmd_valid && cmd_ready) exp_q.push_back(alu_ref(cmd_a, cmd_b, cmd_op));
            if (rsp_valid && rsp_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %h want no response", {rsp_co, rsp_y});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({rsp_co, rsp_y} !== e) begin
                        n_fail++;
                        $display("FAIL rsp_data: got co=%b y=%h want co=%b y=%h", rsp_co, rsp_y, e[8], e[7:0]);
                    end
                end
                exp_cnt = exp_cnt + 16'd1;
                hs_cyc.push_back(cyc);
            end
            hold_chk = rsp_valid && !rsp_ready;
            held     = {rsp_co, rsp_y};
        end else begin
            hold_chk = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int n;
        n = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Reset values
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a_in), 32'd0);
        chk("rst_alu_b", 32'(alu_b_in), 32'd0);
        chk("rst_alu_op", 32'(alu_opcode_in), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);

        // Single op: push at edge p, load at p+1, result valid at p+1+LAT
        rsp_ready = 1'b1;
        cmd_a = 8'h0F; cmd_b = 8'h01; cmd_op = ALU_ADD; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("single_level_push", 32'(fifo_level), 32'd1);
        chk("single_no_bypass", 32'(alu_a_in), 32'd0);
        tick();
        chk("single_alu_a", 32'(alu_a_in), 32'h0F);
        chk("single_alu_b", 32'(alu_b_in), 32'h01);
        chk("single_alu_op", 32'(alu_opcode_in), 32'(ALU_ADD));
        chk("single_level_pop", 32'(fifo_level), 32'd0);
        chk("single_not_yet_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_y", 32'(rsp_y), 32'h10);
        chk("single_co", 32'(rsp_co), 32'd0);
        tick();
        chk("single_op_count", 32'(op_count), 32'd1);
        chk("single_valid_cleared", 32'(rsp_valid), 32'd0);

        // Carry out
        send(8'hFF, 8'h01, ALU_ADD);
        wait_valid();
        chk("carry_y", 32'(rsp_y), 32'h00);
        chk("carry_co", 32'(rsp_co), 32'd1);
        repeat (3) tick();

        // Back-pressure: one op parks in RESP, the rest fill the FIFO
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h20 + i), 8'(8'h03 * i), 4'(i % 5));
            if (i == 3) begin
                chk("bp_level_4acc", 32'(fifo_level), 32'd3);
                chk("bp_ready_4acc", 32'(cmd_ready), 32'd1);
            end
        end
        chk("bp_level_full", 32'(fifo_level), 32'(DEPTH));
        chk("bp_ready_full", 32'(cmd_ready), 32'd0);
        chk("bp_valid_held", 32'(rsp_valid), 32'd1);
        hs_cyc.delete();
        // Full FIFO refuses a push even while the handshake pops
        rsp_ready = 1'b1;
        cmd_a = 8'hAA; cmd_b = 8'h55; cmd_op = ALU_XOR; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("bp_no_push_when_full", 32'(fifo_level), 32'd3);
        begin
            int n;
            n = 0;
            while (hs_cyc.size() < 5 && n < 40) begin
                tick();
                n++;
            end
        end
        chk("bp_drain_count", 32'(hs_cyc.size()), 32'd5);
        for (int i = 1; i < 5 && i < hs_cyc.size(); i++)
            chk("bp_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(LAT + 1));
        tick();
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while in WAIT with two commands queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(8'h40 + i), 8'h11, ALU_ADD);
        wait_valid();
        rsp_ready = 1'b1;
        cmd_a = 8'h77; cmd_b = 8'h01; cmd_op = ALU_ADD; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("mid_level_before", 32'(fifo_level), 32'd2);
        chk("mid_in_wait", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a_in), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
        exp_cnt = '0;
        tick();
        tick();
        reset = 1'b1;
        rsp_ready = 1'b1;
        repeat (8) tick();
        chk("post_rst_no_stale", 32'(rsp_valid), 32'd0);
        chk("post_rst_count", 32'(op_count), 32'd0);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_op    = 4'($urandom_range(0, 4));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        begin
            int n;
            n = 0;
            while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
                tick();
                n++;
            end
        end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // op_count wrap
        force dut.op_count = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        #1;
        release dut.op_count;
        tick();
        chk("wrap_preset", 32'(op_count), 32'hFFFF);
        send(8'h01, 8'h02, ALU_ADD);
        begin
            int n;
            n = 0;
            while (op_count == 16'hFFFF && n < 20) begin
                tick();
                n++;
            end
        end
        chk("wrap_zero", 32'(op_count), 32'h0000);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
